// File: rtl/grf_write_arbiter.sv
// Two-requester write arbiter in front of the GRF's single write port.
// Each requester owns a one-entry holding slot; a round-robin pointer picks
// one valid slot per cycle and the winner is registered onto A3/WD3/WE3.
module grf_write_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic [ADDR_W-1:0] A3,
  output logic [DATA_W-1:0] WD3,
  output logic              WE3,
  output logic              grant_id,
  input  logic [ADDR_W-1:0] query_addr,
  output logic              query_pending
);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;

  // Slot state
  logic [1:0] slot_valid;
  wr_req_t    slot0;
  wr_req_t    slot1;

  // Round-robin pointer: id of the slot that won the most recent tie
  logic       last;

  // Arbitration results (derived from slot state only)
  logic       tie;
  logic       grant_any;
  logic       grant_sel;
  logic       grant0;
  logic       grant1;
  wr_req_t    winner;

  // Handshake decode
  logic       take0;
  logic       take1;
  logic       load0;
  logic       load1;

  // Query comparisons
  logic       hit_slot0;
  logic       hit_slot1;
  logic       hit_port;

  // Pick one valid slot; on a tie the slot that did not win last time goes.
  always_comb begin
    tie       = slot_valid[0] & slot_valid[1];
    grant_any = slot_valid[0] | slot_valid[1];
    grant_sel = 1'b0;
    if (tie) begin
      grant_sel = ~last;
    end else if (slot_valid[1]) begin
      grant_sel = 1'b1;
    end
    grant0 = grant_any & ~grant_sel;
    grant1 = grant_any & grant_sel;
    winner = grant_sel ? slot1 : slot0;
  end

  // A slot can accept when empty or when it is draining this cycle.
  always_comb begin
    req0_ready = ~slot_valid[0] | grant0;
    req1_ready = ~slot_valid[1] | grant1;
    take0      = req0_valid & req0_ready;
    take1      = req1_valid & req1_ready;
    // Writes to $0 complete the handshake but never occupy a slot.
    load0      = take0 & (req0_addr != '0);
    load1      = take1 & (req1_addr != '0);
  end

  // Slot 0: drain on grant, refill on transfer (same edge allowed).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_valid[0] <= 1'b0;
      slot0         <= '0;
    end else begin
      if (grant0) begin
        slot_valid[0] <= 1'b0;
      end
      if (take0) begin
        slot_valid[0] <= load0;
        if (load0) begin
          slot0.addr <= req0_addr;
          slot0.data <= req0_data;
        end
      end
    end
  end

  // Slot 1: drain on grant, refill on transfer (same edge allowed).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_valid[1] <= 1'b0;
      slot1         <= '0;
    end else begin
      if (grant1) begin
        slot_valid[1] <= 1'b0;
      end
      if (take1) begin
        slot_valid[1] <= load1;
        if (load1) begin
          slot1.addr <= req1_addr;
          slot1.data <= req1_data;
        end
      end
    end
  end

  // Round-robin pointer advances only when both slots competed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last <= 1'b1;
    end else if (tie) begin
      last <= grant_sel;
    end
  end

  // Registered GRF write port; address/data hold while idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      WE3      <= 1'b0;
      A3       <= '0;
      WD3      <= '0;
      grant_id <= 1'b0;
    end else begin
      WE3 <= grant_any;
      if (grant_any) begin
        A3       <= winner.addr;
        WD3      <= winner.data;
        grant_id <= grant_sel;
      end
    end
  end

  // Report a register that still has a write in a slot or on the port.
  always_comb begin
    hit_slot0     = slot_valid[0] & (slot0.addr == query_addr);
    hit_slot1     = slot_valid[1] & (slot1.addr == query_addr);
    hit_port      = WE3 & (A3 == query_addr);
    query_pending = (query_addr != '0) & (hit_slot0 | hit_slot1 | hit_port);
  end

endmodule

// File: tb/tb_grf_write_arbiter.sv
// Directed self-checking bench for grf_write_arbiter with a small GRF model.
module tb_grf_write_arbiter;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;

  logic              clk;
  logic              reset;
  logic              req0_valid;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;
  logic              req1_valid;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;
  logic [ADDR_W-1:0] A3;
  logic [DATA_W-1:0] WD3;
  logic              WE3;
  logic              grant_id;
  logic [ADDR_W-1:0] query_addr;
  logic              query_pending;

  int tests;
  int failures;

  logic [DATA_W-1:0] grf [32];

  grf_write_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .req0_valid    (req0_valid),
    .req0_addr     (req0_addr),
    .req0_data     (req0_data),
    .req0_ready    (req0_ready),
    .req1_valid    (req1_valid),
    .req1_addr     (req1_addr),
    .req1_data     (req1_data),
    .req1_ready    (req1_ready),
    .A3            (A3),
    .WD3           (WD3),
    .WE3           (WE3),
    .grant_id      (grant_id),
    .query_addr    (query_addr),
    .query_pending (query_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model driven by the arbiter's write port
  always @(posedge clk) begin
    if (WE3) grf[A3] <= WD3;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_port(input string tag, input logic we, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d, input logic g);
    chk({tag, ".WE3"}, 32'(WE3), 32'(we));
    chk({tag, ".A3"}, 32'(A3), 32'(a));
    chk({tag, ".WD3"}, WD3, d);
    chk({tag, ".gid"}, 32'(grant_id), 32'(g));
  endtask

  // Contention bookkeeping
  logic [ADDR_W-1:0] obs_addr [$];
  logic [DATA_W-1:0] obs_data [$];
  logic              obs_gid  [$];

  initial begin
    int i0;
    int i1;
    logic t0;
    logic t1;
    tests = 0;
    failures = 0;
    for (int r = 0; r < 32; r++) grf[r] = '0;

    // ---------------- Reset with both valids high ----------------
    reset = 1'b0;
    req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'h33;
    req1_valid = 1'b1; req1_addr = 5'd5; req1_data = 32'h55;
    query_addr = 5'd3;
    tick(); tick();
    chk_port("rst", 1'b0, 5'd0, 32'd0, 1'b0);
    chk("rst.ready0", 32'(req0_ready), 32'd1);
    chk("rst.ready1", 32'(req1_ready), 32'd1);
    chk("rst.qp", 32'(query_pending), 32'd0);

    reset = 1'b1;
    tick();                               // both accepted
    req0_valid = 1'b0; req1_valid = 1'b0;
    query_addr = 5'd5;
    #1;
    chk("boot.we_idle", 32'(WE3), 32'd0);
    chk("boot.ready0", 32'(req0_ready), 32'd1);
    chk("boot.ready1", 32'(req1_ready), 32'd0);
    chk("boot.qp5", 32'(query_pending), 32'd1);
    tick();
    chk_port("boot.w0", 1'b1, 5'd3, 32'h33, 1'b0);
    tick();
    chk_port("boot.w1", 1'b1, 5'd5, 32'h55, 1'b1);
    tick();
    chk_port("boot.idle", 1'b0, 5'd5, 32'h55, 1'b1);
    chk("boot.qp5_clear", 32'(query_pending), 32'd0);

    // ---------------- Single write ----------------
    req0_valid = 1'b1; req0_addr = 5'd4; req0_data = 32'd1;
    tick();
    req0_valid = 1'b0;
    chk("single.we_idle", 32'(WE3), 32'd0);
    tick();
    chk_port("single.w", 1'b1, 5'd4, 32'd1, 1'b0);
    tick();
    chk("single.grf4", grf[4], 32'd1);
    chk("single.we_off", 32'(WE3), 32'd0);

    // ---------------- Zero register ----------------
    req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'hFFFF_FFFF;
    query_addr = 5'd0;
    #1;
    chk("zero.ready1", 32'(req1_ready), 32'd1);
    tick();
    req1_valid = 1'b0;
    chk("zero.we0", 32'(WE3), 32'd0);
    chk("zero.qp0", 32'(query_pending), 32'd0);
    chk("zero.ready1_after", 32'(req1_ready), 32'd1);
    tick();
    chk("zero.we1", 32'(WE3), 32'd0);
    chk("zero.grf0", grf[0], 32'd0);

    // ---------------- Mid-operation reset ----------------
    req0_valid = 1'b1; req0_addr = 5'd20; req0_data = 32'hA20;
    req1_valid = 1'b1; req1_addr = 5'd21; req1_data = 32'hA21;
    tick();                               // both slots full, req1 wins the tie
    req0_addr = 5'd22; req0_data = 32'hA22;
    req1_addr = 5'd23; req1_data = 32'hA23;
    #1;
    chk("mid.ready0", 32'(req0_ready), 32'd0);
    chk("mid.ready1", 32'(req1_ready), 32'd1);
    tick();                               // slot1 reloads 23, slot0 still 20
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk_port("mid.w", 1'b1, 5'd21, 32'hA21, 1'b1);
    query_addr = 5'd20;
    #2;
    reset = 1'b0;
    #1;
    chk_port("mid.rst", 1'b0, 5'd0, 32'd0, 1'b0);
    chk("mid.qp20", 32'(query_pending), 32'd0);
    tick();
    #2;
    reset = 1'b1;
    tick();
    chk("mid.quiet0", 32'(WE3), 32'd0);
    tick();
    chk("mid.quiet1", 32'(WE3), 32'd0);
    tick();
    chk("mid.quiet2", 32'(WE3), 32'd0);

    // ---------------- Pending query ----------------
    query_addr = 5'd7;
    req0_valid = 1'b1; req0_addr = 5'd1; req0_data = 32'hB1;
    tick();
    req0_addr = 5'd2; req0_data = 32'hB2;
    req1_valid = 1'b1; req1_addr = 5'd7; req1_data = 32'hB7;
    tick();                               // slot0=2, slot1=7
    req0_addr = 5'd3; req0_data = 32'hB3;
    req1_valid = 1'b0;
    chk_port("pq.w1", 1'b1, 5'd1, 32'hB1, 1'b0);
    chk("pq.qp_a", 32'(query_pending), 32'd1);
    chk("pq.ready1_wait", 32'(req1_ready), 32'd0);
    tick();                               // req0 wins tie, slot1 waits
    req0_valid = 1'b0;
    chk_port("pq.w2", 1'b1, 5'd2, 32'hB2, 1'b0);
    chk("pq.qp_b", 32'(query_pending), 32'd1);
    chk("pq.ready1_go", 32'(req1_ready), 32'd1);
    tick();
    chk_port("pq.w7", 1'b1, 5'd7, 32'hB7, 1'b1);
    chk("pq.qp_c", 32'(query_pending), 32'd1);
    tick();
    chk_port("pq.w3", 1'b1, 5'd3, 32'hB3, 1'b0);
    chk("pq.qp_d", 32'(query_pending), 32'd0);
    tick();
    chk("pq.idle", 32'(WE3), 32'd0);

    // ---------------- Contention ----------------
    i0 = 0;
    i1 = 0;
    for (int c = 0; c < 16; c++) begin
      req0_valid = (i0 < 6);
      req0_addr  = 5'(4 + i0);
      req0_data  = 32'h100 + 32'(4 + i0);
      req1_valid = (i1 < 6);
      req1_addr  = 5'(10 + i1);
      req1_data  = 32'h200 + 32'(10 + i1);
      #1;
      if (c == 1) begin
        chk("cont.ready0_c1", 32'(req0_ready), 32'd1);
        chk("cont.ready1_c1", 32'(req1_ready), 32'd0);
      end
      if (c == 2) begin
        chk("cont.ready0_c2", 32'(req0_ready), 32'd0);
        chk("cont.ready1_c2", 32'(req1_ready), 32'd1);
      end
      t0 = req0_valid & req0_ready;
      t1 = req1_valid & req1_ready;
      tick();
      if (t0) i0++;
      if (t1) i1++;
      if (WE3) begin
        obs_addr.push_back(A3);
        obs_data.push_back(WD3);
        obs_gid.push_back(grant_id);
      end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("cont.count", 32'(obs_addr.size()), 32'd12);
    for (int k = 0; k < 12; k++) begin
      logic [ADDR_W-1:0] ea;
      logic              eg;
      eg = 1'(k % 2);
      ea = eg ? 5'(10 + k / 2) : 5'(4 + k / 2);
      if (k < obs_addr.size()) begin
        chk($sformatf("cont.gid%0d", k), 32'(obs_gid[k]), 32'(eg));
        chk($sformatf("cont.addr%0d", k), 32'(obs_addr[k]), 32'(ea));
        chk($sformatf("cont.data%0d", k), obs_data[k], (eg ? 32'h200 : 32'h100) + 32'(ea));
      end
    end
    chk("cont.grf9", grf[9], 32'h109);
    chk("cont.grf15", grf[15], 32'h20F);
    chk("cont.idle", 32'(WE3), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
